instruction_memory: RTL and testbench

// - Byte-addressed program store for the stack processor.
// - Returns the opcode byte at the program counter and the 32-bit immediate that follows it.
// - Read path is combinational: the core samples it on its slow instruction clock without a wait state.
// - Contents are writable through a clocked load port.
// - Synchronous reset restores the built-in default program.

---
 rtl/stack_isa_pkg.sv | 37 +++
 rtl/instruction_memory.sv | 65 ++++++
 tb/tb_instruction_memory.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/stack_isa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stack_isa_pkg
// Description : Stack-processor opcode constants and the built-in boot image.
// Revision    : 1.0 - initial release
// ============================================================================
package stack_isa_pkg;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_POP   = 8'h02;
    localparam logic [7:0] OP_PUSH  = 8'h10;
    localparam logic [7:0] OP_PUSH0 = 8'h11;
    localparam logic [7:0] OP_INC   = 8'h20;
    localparam logic [7:0] OP_BR    = 8'h30;
    localparam logic [7:0] OP_HALT  = 8'hFF;

    localparam int IMM_BYTES    = 4;
    localparam int INSN_LEN_IMM = 1 + IMM_BYTES;

    // Boot program: push0, inc, push 0x0F, br, (nops), inc, halt.
    function automatic logic [7:0] default_image(input int addr);
        logic [7:0] b;
        case (addr)
            0:       b = OP_PUSH0;
            1:       b = OP_INC;
            2:       b = OP_PUSH;
            3:       b = 8'h0F;
            7:       b = OP_BR;
            15:      b = OP_INC;
            16:      b = OP_HALT;
            default: b = OP_NOP;
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_memory.sv
`default_nettype none
// ============================================================================
// Module      : instruction_memory
// Description : Byte-addressed program store, combinational opcode + imm32 read.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_memory
    import stack_isa_pkg::*;
#(
    parameter  int DEPTH  = 256,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       index,
    output logic [7:0]        instruction,
    output logic [31:0]       constant,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [7:0]        load_data
);

    typedef logic [7:0] mem_t [DEPTH];

    function automatic mem_t image_init();
        mem_t m;
        for (int a = 0; a < DEPTH; a++) begin
            m[a[ADDR_W-1:0]] = default_image(a);
        end
        return m;
    endfunction

    // Power-up value equals the reset image so the core runs without a reset.
    mem_t mem_q = image_init();

    logic [32:0] byte_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int a = 0; a < DEPTH; a++) begin
                mem_q[a[ADDR_W-1:0]] <= default_image(a);
            end
        end else if (load_we) begin
            mem_q[load_addr] <= load_data;
        end
    end

    // Bounds checks in 33 bits so a PC near 2^32-1 cannot wrap into the array.
    always_comb begin
        instruction = OP_HALT;
        constant    = '0;
        byte_addr   = '0;
        if ({1'b0, index} < 33'(DEPTH)) begin
            instruction = mem_q[index[ADDR_W-1:0]];
        end
        for (int k = 0; k < IMM_BYTES; k++) begin
            byte_addr = {1'b0, index} + 33'(k + 1);
            if (byte_addr < 33'(DEPTH)) begin
                constant[8*k +: 8] = mem_q[byte_addr[ADDR_W-1:0]];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instruction_memory.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_memory
// Description : Directed, table-driven self-checking bench for instruction_memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_memory;

    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [31:0]       index = '0;
    logic [7:0]        instruction;
    logic [31:0]       constant;
    logic              load_we = 1'b0;
    logic [ADDR_W-1:0] load_addr = '0;
    logic [7:0]        load_data = '0;

    int n_tests = 0;
    int n_fail  = 0;

    instruction_memory #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .index       (index),
        .instruction (instruction),
        .constant    (constant),
        .load_we     (load_we),
        .load_addr   (load_addr),
        .load_data   (load_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          phase;
        logic [31:0] idx;
        logic [7:0]  exp_insn;
        logic [31:0] exp_const;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [7:0] exp_insn,
                         input logic [31:0] exp_const);
        n_tests++;
        if (instruction !== exp_insn || constant !== exp_const) begin
            n_fail++;
            $display("FAIL %s: got insn=%02h const=%08h, expected insn=%02h const=%08h",
                     name, instruction, constant, exp_insn, exp_const);
        end
    endtask

    task automatic load(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        @(negedge clk);
        load_we   = 1'b1;
        load_addr = a;
        load_data = d;
        @(posedge clk);
        #1;
        load_we   = 1'b0;
    endtask

    task automatic run_phase(input int ph);
        foreach (vecs[i]) begin
            if (vecs[i].phase == ph) begin
                index = vecs[i].idx;
                #1;
                check(vecs[i].name, vecs[i].exp_insn, vecs[i].exp_const);
            end
        end
    endtask

    initial begin
        vecs.push_back('{0, 32'd0,        8'h11, 32'h000F1020, "idx0"});
        vecs.push_back('{0, 32'd1,        8'h20, 32'h00000F10, "idx1"});
        vecs.push_back('{0, 32'd2,        8'h10, 32'h0000000F, "idx2_push"});
        vecs.push_back('{0, 32'd7,        8'h30, 32'h00000000, "idx7_br"});
        vecs.push_back('{0, 32'd8,        8'h00, 32'h00000000, "idx8_nop"});
        vecs.push_back('{0, 32'd15,       8'h20, 32'h000000FF, "idx15_inc"});
        vecs.push_back('{0, 32'd16,       8'hFF, 32'h00000000, "idx16_halt"});
        vecs.push_back('{0, 32'd256,      8'hFF, 32'h00000000, "idx_depth"});
        vecs.push_back('{0, 32'hFFFFFFFF, 8'hFF, 32'h00000000, "idx_max"});
        vecs.push_back('{0, 32'd255,      8'h00, 32'h00000000, "idx255_pre"});
        vecs.push_back('{1, 32'h40,       8'h10, 32'hDEADBEEF, "idx40_loaded"});
        vecs.push_back('{1, 32'h3F,       8'h00, 32'hADBEEF10, "idx3F_loaded"});
        vecs.push_back('{1, 32'hFE,       8'h10, 32'h000000AB, "idxFE_edge"});
        vecs.push_back('{1, 32'hFF,       8'hAB, 32'h00000000, "idxFF_edge"});
        vecs.push_back('{1, 32'hFFFFFFFC, 8'hFF, 32'h00000000, "idx_nearmax"});

        // Power-up contents before any reset
        index = 32'd0;
        #1;
        check("powerup_idx0", 8'h11, 32'h000F1020);

        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_phase(0);

        load(8'h40, 8'h10);
        load(8'h41, 8'hEF);
        load(8'h42, 8'hBE);
        load(8'h43, 8'hAD);
        load(8'h44, 8'hDE);
        load(8'hFE, 8'h10);
        load(8'hFF, 8'hAB);
        run_phase(1);

        // Write to the byte being read must not show before the edge
        @(negedge clk);
        index     = 32'h20;
        load_we   = 1'b1;
        load_addr = 8'h20;
        load_data = 8'h5A;
        #1;
        check("write_before_edge", 8'h00, 32'h00000000);
        @(posedge clk);
        #1;
        load_we = 1'b0;
        check("write_after_edge", 8'h5A, 32'h00000000);

        // Reset has priority over a simultaneous load
        @(negedge clk);
        rst       = 1'b1;
        load_we   = 1'b1;
        load_addr = 8'h00;
        load_data = 8'h00;
        index     = 32'd0;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        load_we = 1'b0;
        check("rst_beats_load", 8'h11, 32'h000F1020);

        load(8'h00, 8'h00);
        index = 32'd0;
        #1;
        check("load_after_rst", 8'h00, 32'h000F1020);

        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        index = 32'h40;
        #1;
        check("rst_clears_40", 8'h00, 32'h00000000);
        index = 32'h20;
        #1;
        check("rst_clears_20", 8'h00, 32'h00000000);
        index = 32'd0;
        #1;
        check("rst_restores_0", 8'h11, 32'h000F1020);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
